// File: rtl/common_pkg.sv
// Shared types and constants for the UART receive path.
package common_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// UART serial-to-byte receiver: 8 data bits LSB first, mid-bit sampling, stop check.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD = 1).
module uart_rx_byte
    import common_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_ODD   = 0
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_bad_q, par_bad_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      perr_q, perr_d;
    logic                      bit_tick;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (rx_serial),
        .q       (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_INV = (PARITY_ODD != 0);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign bit_tick = (cnt_q == BIT_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q) ^ PARITY_INV;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        // A framing error takes precedence over any parity mismatch.
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign byte_data    = data_q;
    assign byte_valid   = valid_q;
    assign frame_error  = ferr_q;
    assign parity_error = perr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: vector table, corner sequences, and randomized
// frames compared against a frame-level reference decoder of the recorded line.
module tb_uart_rx_byte;

    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum int { EV_VALID, EV_FERR, EV_PERR } ev_kind_e;

    typedef struct {
        int        edge_no;
        ev_kind_e  kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        ev_kind_e   kind;
    } vec_t;

    logic       sys_clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_error;
    logic       parity_error;

    logic line_hist[$];
    ev_t  all_ev[$];
    ev_t  exp_ev[$];
    int   base_edge = 0;
    int   errors    = 0;
    int   checks    = 0;

    uart_rx_byte #(
        .CLKS_PER_BIT (C),
        .PARITY_ODD   (PODD)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .rx_serial    (rx_serial),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Line value seen at each rising edge; index = edge number.
    always @(posedge sys_clk) line_hist.push_back(rx_serial);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        int n;
        n = $countones({byte_valid, frame_error, parity_error});
        if (n != 0) begin
            check("pulse_onehot", n, 1);
            if (byte_valid)   all_ev.push_back('{line_hist.size() - 1, EV_VALID, byte_data});
            if (frame_error)  all_ev.push_back('{line_hist.size() - 1, EV_FERR, byte_data});
            if (parity_error) all_ev.push_back('{line_hist.size() - 1, EV_PERR, byte_data});
        end
    end

    task automatic drive(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                              output int start_edge);
        start_edge = line_hist.size();
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(d[i], C);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ (PODD != 0) ^ par_flip, C);
`else
        if (par_flip) drive(1'b1, 0);
`endif
        drive(stop_bit, C);
    endtask

    // Pulse expected after the stop sample: pin delay 2, then H + (frame bits - 1) bit times.
    task automatic check_frame(input string tag, input int idx, input int se,
                               input ev_kind_e kind, input logic [7:0] data);
        if (all_ev.size() > idx) begin
            check({tag, "_kind"}, all_ev[idx].kind, kind);
            check({tag, "_time"}, all_ev[idx].edge_no, se + 2 + H + (FRAME_BITS - 1) * C);
            if (kind == EV_VALID) check({tag, "_data"}, all_ev[idx].data, data);
        end
    endtask

    function automatic logic seen(input int e);
        if (e - 2 < base_edge) return 1'b1;
        return line_hist[e - 2];
    endfunction

    // Reference decoder: walks the recorded line using the spec's sample-point arithmetic.
    task automatic run_model(input int last_edge);
        int e, e0, es;
        logic [7:0] d;
        logic bad;
        exp_ev.delete();
        e = base_edge;
        while (e <= last_edge) begin
            if (seen(e)) begin
                e++;
            end else begin
                e0 = e;
                if (e0 + H > last_edge) break;
                if (seen(e0 + H)) begin
                    e = e0 + H + 1;
                end else begin
                    es = e0 + H + (FRAME_BITS - 1) * C;
                    if (es > last_edge) break;
                    for (int i = 0; i < 8; i++) d[i] = seen(e0 + H + (i + 1) * C);
                    bad = 1'b0;
`ifdef UART_RX_PARITY_EN
                    bad = (seen(e0 + H + 9 * C) != ((^d) ^ (PODD != 0)));
`endif
                    e = es + 1;
                    if (seen(es)) begin
                        exp_ev.push_back('{es, bad ? EV_PERR : EV_VALID, d});
                    end else begin
                        exp_ev.push_back('{es, EV_FERR, d});
                        while (e <= last_edge && !seen(e)) e++;
                        e++;
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t       vecs[$];
        int         se, se2, idx0, r;
        logic [7:0] hold, tmp;
        logic       stop;

        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_parity_error", parity_error, 1'b0);
        rst       = 1'b0;
        base_edge = line_hist.size();
        drive(1'b1, 2 * C);

        vecs.push_back('{8'hA5, 1'b1, 1'b0, EV_VALID});
        vecs.push_back('{8'h00, 1'b1, 1'b0, EV_VALID});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, EV_VALID});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, EV_FERR});
        vecs.push_back('{8'h12, 1'b1, 1'b0, EV_VALID});
        vecs.push_back('{8'h81, 1'b0, 1'b0, EV_FERR});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b1, EV_PERR});
        vecs.push_back('{8'h03, 1'b1, 1'b0, EV_VALID});
        vecs.push_back('{8'h7E, 1'b0, 1'b1, EV_FERR});
`endif
        hold = 8'h00;
        foreach (vecs[i]) begin
            idx0 = all_ev.size();
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, se);
            drive(1'b1, 2 * C);
            if (vecs[i].kind == EV_VALID) hold = vecs[i].data;
            check("vec_count", all_ev.size() - idx0, 1);
            check_frame("vec", idx0, se, vecs[i].kind, vecs[i].data);
            check("vec_hold", byte_data, hold);
        end

        // Back-to-back frames with no idle gap.
        idx0 = all_ev.size();
        send_frame(8'h00, 1'b1, 1'b0, se);
        send_frame(8'hFF, 1'b1, 1'b0, se2);
        drive(1'b1, 2 * C);
        check("b2b_count", all_ev.size() - idx0, 2);
        check_frame("b2b_first", idx0, se, EV_VALID, 8'h00);
        check_frame("b2b_second", idx0 + 1, se2, EV_VALID, 8'hFF);

        // Short glitches, including one exactly H cycles long, are rejected.
        idx0 = all_ev.size();
        drive(1'b0, 3);
        drive(1'b1, 3 * C);
        drive(1'b0, H);
        drive(1'b1, 3 * C);
        check("glitch_no_pulse", all_ev.size() - idx0, 0);

        // One cycle longer passes the start check and reads an all-ones frame.
        idx0 = all_ev.size();
        se   = line_hist.size();
        drive(1'b0, H + 1);
        drive(1'b1, 12 * C);
        check("long_start_count", all_ev.size() - idx0, 1);
`ifdef UART_RX_PARITY_EN
        check_frame("long_start", idx0, se, EV_PERR, 8'hFF);
`else
        check_frame("long_start", idx0, se, EV_VALID, 8'hFF);
`endif

        // Framing error followed by a held-low break, then a good frame.
        idx0 = all_ev.size();
        send_frame(8'h3C, 1'b0, 1'b0, se);
        drive(1'b0, 40);
        check("break_count", all_ev.size() - idx0, 1);
        check_frame("break_ferr", idx0, se, EV_FERR, 8'h00);
        drive(1'b1, C);
        send_frame(8'h12, 1'b1, 1'b0, se);
        drive(1'b1, 2 * C);
        check("after_break_count", all_ev.size() - idx0, 2);
        check_frame("after_break", idx0 + 1, se, EV_VALID, 8'h12);

        // Randomized traffic; everything since reset is compared with the reference decoder.
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(1'b0, $urandom_range(1, H + 2));
                drive(1'b1, 12 * C);
            end else begin
                stop = (r != 1);
`ifdef UART_RX_PARITY_EN
                send_frame(8'($urandom), stop, ($urandom_range(0, 3) == 0), se);
`else
                send_frame(8'($urandom), stop, 1'b0, se);
`endif
                if (!stop) drive(1'b0, $urandom_range(0, 40));
                drive(1'b1, $urandom_range(0, C));
            end
        end
        drive(1'b1, 3 * C);
        run_model(line_hist.size() - 1);
        check("model_count", all_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < all_ev.size(); i++) begin
            check("model_time", all_ev[i].edge_no, exp_ev[i].edge_no);
            check("model_kind", all_ev[i].kind, exp_ev[i].kind);
            if (exp_ev[i].kind == EV_VALID) check("model_data", all_ev[i].data, exp_ev[i].data);
        end

        // Reset in the middle of data bit 4 aborts the frame.
        idx0 = all_ev.size();
        tmp  = 8'hC3;
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(tmp[i], C);
        drive(tmp[4], H);
        rst = 1'b1;
        @(negedge sys_clk);
        rst       = 1'b0;
        rx_serial = 1'b1;
        check("midrst_byte_data", byte_data, 8'h00);
        check("midrst_byte_valid", byte_valid, 1'b0);
        check("midrst_frame_error", frame_error, 1'b0);
        check("midrst_parity_error", parity_error, 1'b0);
        drive(1'b1, 12 * C);
        check("midrst_no_pulse", all_ev.size() - idx0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, se);
        drive(1'b1, 2 * C);
        check("post_rst_count", all_ev.size() - idx0, 1);
        check_frame("post_rst", idx0, se, EV_VALID, 8'h5A);
        check("post_rst_hold", byte_data, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-byte UART receiver placed directly upstream of the instruction-loading UART collector. It synchronises the raw `rx_serial` pin, detects and qualifies start bits, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and, optionally, a parity bit, then delivers each good byte as a single-cycle `byte_valid` pulse. The collector assembles these bytes into instruction words; this block knows nothing about words, addresses or `start`.

## Interface
- `CLKS_PER_BIT`, default 868: `sys_clk` cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.
- `sys_clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_serial`, input, 1: asynchronous UART line; idles high.
- `byte_data`, output, 8: last received good byte. Holds its value until the next good byte.
- `byte_valid`, output, 1: one-cycle pulse; `byte_data` is valid in the same cycle.
- `frame_error`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_error`, output, 1: one-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.

## Operation
- Input synchroniser: 2-flop, reset value 1. All decisions use the synchronised line `rx_s`.
- States and transitions:
  - IDLE: go to START on the first cycle with `rx_s == 0`. Record that cycle as T0.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then resample. If `rx_s == 1` (glitch), return to IDLE with no output. If `rx_s == 0`, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Bit i (0..7) goes into shift position i (LSB first). After bit 7, go to PARITY if compiled in, otherwise go to STOP.
  - PARITY: sample one bit. The expected value is XOR of the data bits, inverted when `PARITY_ODD = 1`. Store the mismatch flag.
  - STOP: sample one bit.
    - Sample = 1 and no parity mismatch: pulse `byte_valid` and load `byte_data`. Go to IDLE.
    - Sample = 1 with parity mismatch: pulse `parity_error` only. Go to IDLE.
    - Sample = 0: pulse `frame_error` only; `parity_error` is suppressed. Go to BREAK.
  - BREAK: stay until `rx_s == 1`, then go to IDLE. No new frame can start while the line is held low.
- Bit-timer counter width is `$clog2(CLKS_PER_BIT)`. It reloads on every sample point and does not free-run.
- Reset values: state IDLE, `byte_data` 8'h00, `byte_valid` 0, `frame_error` 0, `parity_error` 0, all counters 0, shift register 0.
- Reset mid-frame aborts the frame. No output pulse is produced; the next frame must start from a fresh falling edge.

## Timing
- Pin-to-`rx_s` delay: 2 cycles.
- Sample points, relative to T0 (H = `CLKS_PER_BIT/2`, C = `CLKS_PER_BIT`):
  - start check: T0 + H
  - data bit i: T0 + H + (i+1)·C
  - parity: T0 + H + 9·C
  - stop: T0 + H + 9·C without parity, T0 + H + 10·C with parity
- Output pulses (`byte_valid`, `frame_error`, `parity_error`) are registered and occur in the cycle after the stop sample. At most one of them is high in any cycle.
- Back-to-back frames are supported. After a good stop the FSM is in IDLE within 1 cycle, so a start bit beginning immediately after the nominal stop bit is caught.
- There is no backpressure. The consumer must accept `byte_valid` in the cycle it is asserted.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the frame is 11 bits, `parity_error` is live, and `PARITY_ODD` is honoured.
- `UART_RX_PARITY_EN` undefined: 8N1 frame, no PARITY state, `parity_error` tied to 0, `PARITY_ODD` ignored.

## Structure
- `common_pkg` holds:
  - `uart_rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - `UART_DATA_BITS = 8`.
  - Default `CLKS_PER_BIT` constant.
- One sub-module, `sync_2ff`: generic 2-flop synchroniser with a reset-value parameter (used with 1 here). It is reusable for other asynchronous inputs.

## Test plan
All scenarios use `CLKS_PER_BIT = 16`.
1. Send 0xA5 (8N1) → exactly one `byte_valid` pulse with `byte_data = 0xA5`, at cycle T0 + 8 + 9·16 + 1. Error outputs stay 0.
2. Send 0x00 then 0xFF back-to-back with no idle gap → two `byte_valid` pulses, carrying 0x00 then 0xFF.
3. Drive the line low for 3 cycles, then high → no output pulse; FSM returns to IDLE.
4. Send 0x3C with stop bit = 0, then hold the line low for 40 cycles, then high → one `frame_error` pulse and no `byte_valid`. No further activity until the line returns high; the next valid 0x12 is then received correctly.
5. With `UART_RX_PARITY_EN` defined and even parity: send 0x03 with parity bit 1 → one `parity_error` pulse and no `byte_valid`. Send 0x03 with parity bit 0 → `byte_valid` with `byte_data = 0x03`.
6. Assert `rst` for 1 cycle during data bit 4 of a frame → no output pulse for that frame, all outputs at reset values, and a following 0x5A is received correctly.
